imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
- Boot-time controller that owns the write side of the instruction memory and sequences core start-up.
- After reset it holds the core in reset and accepts a little-endian byte stream from the loader (UART/debug bridge). It packs the bytes into 32-bit words and writes them to consecutive word addresses from 0.
- It then releases the core and passes fetch addresses and instructions through to the core.
- Sits between the loader, the instruction memory and the core's fetch stage.

Parameters:
- ADDR_W, 10, word-address width of instruction memory (depth = 2**ADDR_W).
- DATA_W, 32, instruction width; fixed at 4 bytes per word.
- NOP_INSTR, 32'h00000013, instruction returned to fetch while not in RUN (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; returns the block to LOAD
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader data byte
- ld_last  in  1  qualifies the final byte of the image (valid only with ld_valid)
- ld_ready  out  1  block accepts the byte this cycle (transfer = ld_valid & ld_ready)
- mem_we  out  1  instruction memory write enable
- mem_waddr  out  ADDR_W  write word address
- mem_wdata  out  32  write data
- mem_raddr  out  ADDR_W  read word address to memory
- mem_rdata  in  32  combinational read data from memory
- fetch_addr  in  ADDR_W  word address from core PC
- fetch_instr  out  32  instruction to core
- core_reset  out  1  hold core in reset
- boot_done  out  1  image loaded, core running
- err_overflow  out  1  sticky: image exceeded memory depth
- words_loaded  out  ADDR_W+1  count of words written

Behaviour:
- State machine states are LOAD, WRITE and RUN. All outputs are driven from registers or from the state register; there are no combinational paths from loader inputs to outputs.
- Reset values: state=LOAD, byte_cnt=0, wptr=0, word buffer=0, last_pend=0, words_loaded=0, err_overflow=0. Outputs at reset: mem_we=0, core_reset=1, boot_done=0, ld_ready=1, fetch_instr=NOP_INSTR.
- LOAD state:
  - ld_ready=1.
  - On each transfer, ld_byte goes into byte lane byte_cnt (lane 0 = bits 7:0) and byte_cnt increments.
  - The state moves to WRITE when the transfer is the 4th byte (byte_cnt==3), or when ld_last=1 on any byte. In the ld_last case, unfilled upper lanes are zero; last_pend is set.
  - A cycle with ld_valid=0 holds all state.
- WRITE state (exactly 1 cycle):
  - ld_ready=0; mem_we=1; mem_waddr=wptr; mem_wdata=assembled word.
  - Next edge: words_loaded increments, byte_cnt and the buffer clear, and wptr increments modulo depth.
  - Next state is RUN if last_pend=1.
  - Next state is also RUN if wptr==depth-1 without last_pend; in that case err_overflow is set.
  - Otherwise the next state is LOAD.
- Throughput: max 4 bytes per 5 cycles. Write latency is 1 cycle after the accepting edge of the word's final byte.
- RUN state:
  - core_reset=0 and boot_done=1 from the first RUN cycle.
  - ld_ready=0; loader bytes are ignored.
  - mem_raddr=fetch_addr; fetch_instr=mem_rdata, with zero added latency.
- Outside RUN: core_reset=1, boot_done=0, fetch_instr=NOP_INSTR, mem_raddr=0.
- Boundaries:
  - An image of exactly depth words with ld_last on the final byte gives RUN with err_overflow=0.
  - If ld_last arrives on a 4th byte, exactly one write occurs, with no extra padded word.
  - Reset mid-load or in RUN: partial word discarded, memory contents untouched, core re-held in reset, and a new image is loaded from address 0.
  - Reset has priority over all other events in the same cycle.
- words_loaded saturates naturally at depth, because no further writes occur.

Decomposition:
- Package imem_boot_pkg:
  - state enum {LOAD, WRITE, RUN}
  - NOP_INSTR constant
  - BYTES_PER_WORD=4
- Sub-module imem_byte_packer:
  - owns byte_cnt and the word buffer
  - inputs: push, byte, last, clear
  - outputs: word, word_ready, last_seen
- The FSM, write pointer, counters and fetch mux stay in the top level.

Test Plan:
- Stream 00 93 05 00 | 13 01 A0 00 with ld_last on the 8th byte, ld_valid continuous. Required response:
  - writes mem[0]=32'h00059300 and mem[1]=32'h00A00113
  - ld_ready low on each WRITE cycle
  - core_reset falls the cycle after the 2nd write
  - words_loaded=2
- Partial final word: bytes 13 00 00 00, then AB with ld_last. Required: mem[1]=32'h000000AB, RUN entered, err_overflow=0.
- Gapped loader: ld_valid toggling 1/0 for 8 bytes. Required: same memory contents as the continuous case, with no byte lost or duplicated.
- Overflow: stream 1025 words with no ld_last. Required:
  - 1024 writes, addresses 0..1023
  - err_overflow=1, RUN entered after the write to 1023
  - remaining bytes see ld_ready=0
- Reset after 6 bytes, then reload a 1-word image DEADBEEF (bytes EF BE AD DE, ld_last). Required: mem[0]=32'hDEADBEEF, words_loaded=1, no write to addr 1.
- In RUN, drive fetch_addr=0 then 1. Required: fetch_instr equals mem_rdata in the same cycle. Before RUN, fetch_instr=32'h00000013 and core_reset=1.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } boot_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; lane 0 is bits 7:0.
module imem_byte_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  data,
  input  logic        last,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        last_seen
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt  <= '0;
      word      <= '0;
      last_seen <= 1'b0;
    end else if (push) begin
      word[{byte_cnt, 3'b000} +: 8] <= data;
      byte_cnt                      <= byte_cnt + 2'd1;
      if (last) last_seen <= 1'b1;
    end
  end

  // Buffer is cleared after every word, so unfilled upper lanes stay zero.
  assign word_ready = push && ((byte_cnt == 2'(BYTES_PER_WORD - 1)) || last);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller: loads an image into instruction memory, then releases the core.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = imem_boot_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              core_reset,
  output logic              boot_done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   words_loaded
);

  boot_state_t       state, state_next;
  logic [ADDR_W-1:0] wptr;
  logic [31:0]       word;
  logic              word_ready;
  logic              last_pend;
  logic              push;
  logic              clear;

  assign push  = ld_valid && (state == LOAD);
  assign clear = (state == WRITE);

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .data       (ld_byte),
    .last       (ld_last),
    .clear      (clear),
    .word       (word),
    .word_ready (word_ready),
    .last_seen  (last_pend)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (word_ready) state_next = WRITE;
      WRITE:   begin
        if (last_pend || (wptr == '1)) state_next = RUN;
        else                           state_next = LOAD;
      end
      RUN:     state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      words_loaded <= '0;
      err_overflow <= 1'b0;
    end else if (state == WRITE) begin
      wptr         <= wptr + ADDR_W'(1);
      words_loaded <= words_loaded + (ADDR_W + 1)'(1);
      if (!last_pend && (wptr == '1)) err_overflow <= 1'b1;
    end
  end

  always_comb begin
    ld_ready    = (state == LOAD);
    mem_we      = (state == WRITE);
    mem_waddr   = wptr;
    mem_wdata   = DATA_W'(word);
    core_reset  = 1'b1;
    boot_done   = 1'b0;
    mem_raddr   = '0;
    fetch_instr = DATA_W'(NOP_INSTR);
    if (state == RUN) begin
      core_reset  = 1'b0;
      boot_done   = 1'b1;
      mem_raddr   = fetch_addr;
      fetch_instr = mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl with a behavioural instruction memory.
module tb_imem_boot_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              ld_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_instr;
  logic              core_reset;
  logic              boot_done;
  logic              err_overflow;
  logic [ADDR_W:0]   words_loaded;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] obs_q[$];
  logic [31:0]        exp_word;
  int unsigned        exp_cnt;
  int unsigned        exp_addr;

  int tests = 0;
  int fails = 0;

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr),
    .core_reset   (core_reset),
    .boot_done    (boot_done),
    .err_overflow (err_overflow),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  always @(negedge clk) if (mem_we) obs_q.push_back({mem_waddr, mem_wdata});

  // All tasks start and end on a falling edge.
  task automatic do_reset();
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    exp_word = '0;
    exp_cnt  = 0;
    exp_addr = 0;
  endtask

  task automatic idle(input int n);
    ld_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    while (!ld_ready && n < 20) begin
      ld_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!ld_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: ld_ready=%b required 1", ld_ready);
      return;
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    exp_word = exp_word | (32'(b) << (8 * exp_cnt));
    exp_cnt++;
    if ((exp_cnt == 4 || last) && exp_addr < DEPTH) begin
      exp_q.push_back({exp_addr[ADDR_W-1:0], exp_word});
      exp_addr++;
      exp_word = '0;
      exp_cnt  = 0;
    end
  endtask

  task automatic compare_writes(input string name);
    logic [ADDR_W+31:0] e, o;
    idle(3);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: writes=%0d required %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s_write: addr=%0d data=%h required addr=%0d data=%h",
                 name, o[ADDR_W+31:32], o[31:0], e[ADDR_W+31:32], e[31:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    fetch_addr = 10'd5;
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_we, core_reset, boot_done, ld_ready, err_overflow} !== 5'b01010 ||
        fetch_instr !== 32'h13 || words_loaded !== '0 || mem_raddr !== '0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b crst=%b done=%b rdy=%b ovf=%b instr=%h wl=%0d raddr=%0d required 0 1 0 1 0 00000013 0 0",
               mem_we, core_reset, boot_done, ld_ready, err_overflow, fetch_instr, words_loaded, mem_raddr);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [7:0] img [8];
    img = '{8'h00, 8'h93, 8'h05, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(img[i], i == 7);
      if (i == 3 || i == 7) begin
        tests++;
        if (ld_ready !== 1'b0 || mem_we !== 1'b1 || core_reset !== 1'b1) begin
          fails++;
          $display("FAIL basic_write_cycle%0d: rdy=%b we=%b crst=%b required 0 1 1", i, ld_ready, mem_we, core_reset);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (core_reset !== 1'b0 || boot_done !== 1'b1) begin
      fails++;
      $display("FAIL basic_release: crst=%b done=%b required 0 1", core_reset, boot_done);
    end
    tests++;
    if (exp_q.size() != 2 || exp_q[0][31:0] !== 32'h0005_9300 || exp_q[1][31:0] !== 32'h00A0_0113) begin
      fails++;
      $display("FAIL basic_model: queued=%0d required 2 words 00059300 00a00113", exp_q.size());
    end
    compare_writes("basic");
    tests++;
    if (words_loaded !== 11'd2 || err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL basic_words: wl=%0d ovf=%b required 2 0", words_loaded, err_overflow);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] want [2];
    want = '{32'h0005_9300, 32'h00A0_0113};
    for (int i = 0; i < 2; i++) begin
      fetch_addr = ADDR_W'(i);
      #1;
      tests++;
      if (fetch_instr !== want[i] || mem_raddr !== ADDR_W'(i)) begin
        fails++;
        $display("FAIL fetch_%0d: instr=%h raddr=%0d required %h %0d", i, fetch_instr, mem_raddr, want[i], i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_partial();
    logic [7:0] img [5];
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hAB};
    do_reset();
    for (int i = 0; i < 5; i++) send(img[i], i == 4);
    compare_writes("partial");
    tests++;
    if (mem[1] !== 32'h0000_00AB || boot_done !== 1'b1 || err_overflow !== 1'b0 || words_loaded !== 11'd2) begin
      fails++;
      $display("FAIL partial_state: mem1=%h done=%b ovf=%b wl=%0d required 000000ab 1 0 2",
               mem[1], boot_done, err_overflow, words_loaded);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] img [8];
    img = '{8'h00, 8'h93, 8'h05, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(img[i], i == 7);
      idle(1);
    end
    compare_writes("gapped");
    tests++;
    if (mem[0] !== 32'h0005_9300 || mem[1] !== 32'h00A0_0113 || words_loaded !== 11'd2) begin
      fails++;
      $display("FAIL gapped_mem: mem0=%h mem1=%h wl=%0d required 00059300 00a00113 2", mem[0], mem[1], words_loaded);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 1'b0);
    compare_writes("midload_pre");
    do_reset();
    tests++;
    if (core_reset !== 1'b1 || words_loaded !== '0 || ld_ready !== 1'b1) begin
      fails++;
      $display("FAIL midload_reset: crst=%b wl=%0d rdy=%b required 1 0 1", core_reset, words_loaded, ld_ready);
    end
    send(8'hEF, 1'b0); send(8'hBE, 1'b0); send(8'hAD, 1'b0); send(8'hDE, 1'b1);
    compare_writes("midload_reload");
    tests++;
    if (mem[0] !== 32'hDEAD_BEEF || words_loaded !== 11'd1 || boot_done !== 1'b1) begin
      fails++;
      $display("FAIL midload_result: mem0=%h wl=%0d done=%b required deadbeef 1 1", mem[0], words_loaded, boot_done);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < 4; b++) send(8'(w + b * 17), 1'b0);
    compare_writes("overflow");
    tests++;
    if (err_overflow !== 1'b1 || boot_done !== 1'b1 || words_loaded !== 11'(DEPTH)) begin
      fails++;
      $display("FAIL overflow_state: ovf=%b done=%b wl=%0d required 1 1 %0d", err_overflow, boot_done, words_loaded, DEPTH);
    end
    for (int b = 0; b < 4; b++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'hC0;
      tests++;
      if (ld_ready !== 1'b0) begin
        fails++;
        $display("FAIL overflow_ready: rdy=%b required 0", ld_ready);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    compare_writes("overflow_tail");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fetch();
    test_partial();
    test_gapped();
    test_reset_midload();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
